// File: rtl/peak_readout_ctrl.sv
// peak_readout_ctrl: ping-pong snapshot of peak frames for host readout,
// with a lock/release handshake so the host never sees a torn frame.
module peak_readout_ctrl #(
  parameter int PEAKS      = 6,
  parameter int FREQ_WIDTH = 8,
  parameter int AMPL_WIDTH = 24,
  parameter int TIME_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [TIME_WIDTH-1:0]       counter_in,
  input  logic [PEAKS*FREQ_WIDTH-1:0] freqs_in,
  input  logic [PEAKS*AMPL_WIDTH-1:0] ampls_in,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic [7:0]                  address,
  input  logic [7:0]                  writedata,
  output logic [7:0]                  readdata,
  output logic                        frame_ready
);
  localparam int NB = 4 + 4 * PEAKS;
  localparam int AW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, READY, LOCKED} state_t;
  state_t state_q, state_d;
  logic back_full_q, back_full_d, front_sel_q, front_sel_d;
  logic rdy_lock_q, rdy_lock_d, overrun_q, overrun_d;
  logic [7:0] drop_q, drop_d, seq_q, seq_d, readdata_q, rd_d;
  logic [TIME_WIDTH-1:0] cnt_q [2];
  logic [PEAKS*FREQ_WIDTH-1:0] freqs_q [2];
  logic [PEAKS*AMPL_WIDTH-1:0] ampls_q [2];
  logic host_wr, lock_wr, rel_wr, clr_wr, swap, lost, wb;
  logic [7:0] fbytes [2**AW];
  logic unused_wdata;
  assign unused_wdata = ^{writedata[7:3], writedata[1]};
  assign frame_ready = (state_q == READY) | ((state_q == LOCKED) & rdy_lock_q);
  assign readdata = readdata_q;
  always_comb begin
    host_wr = chipselect & write & (address == 8'hF0);
    lock_wr = host_wr & writedata[0];
    rel_wr = host_wr & ~writedata[0];
    clr_wr = host_wr & writedata[2];
    swap = back_full_q & (state_q != LOCKED);
    // a frame is lost when the locked back bank is overwritten or an unread front is replaced
    lost = (valid_in & back_full_q & ~swap) | (swap & (state_q == READY) & ~rel_wr);
    wb = swap ? front_sel_q : ~front_sel_q;
    front_sel_d = front_sel_q ^ swap;
    back_full_d = valid_in | (back_full_q & ~swap);
    seq_d = seq_q + {7'd0, swap};
    drop_d = drop_q + {7'd0, lost & (drop_q != 8'hFF)};
    overrun_d = lost | (overrun_q & ~clr_wr);
    state_d = lock_wr ? LOCKED : swap ? READY : rel_wr ? IDLE : state_q;
    rdy_lock_d = (lock_wr & (state_q != LOCKED)) ? ((state_q == READY) | swap) :
                 rel_wr ? 1'b0 : rdy_lock_q;
  end
  always_comb begin
    for (int k = 0; k < 2**AW; k++) fbytes[k] = 8'h00;
    for (int b = 0; b < 4; b++) fbytes[b] = cnt_q[front_sel_q][8*(3-b) +: 8];
    for (int i = 0; i < PEAKS; i++) begin
      fbytes[4+i] = freqs_q[front_sel_q][FREQ_WIDTH*i +: 8];
      for (int j = 0; j < 3; j++)
        fbytes[4+PEAKS+3*i+j] = ampls_q[front_sel_q][AMPL_WIDTH*i + 8*(2-j) +: 8];
    end
    rd_d = (int'(address) < NB) ? fbytes[address[AW-1:0]] :
           (address == 8'hF0) ? {5'd0, overrun_q, state_q == LOCKED, frame_ready} :
           (address == 8'hF1) ? drop_q :
           (address == 8'hF2) ? seq_q : 8'h00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      back_full_q <= 1'b0;
      front_sel_q <= 1'b0;
      rdy_lock_q <= 1'b0;
      overrun_q <= 1'b0;
      drop_q <= 8'h00;
      seq_q <= 8'h00;
      readdata_q <= 8'h00;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= '0;
        freqs_q[k] <= '0;
        ampls_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      back_full_q <= back_full_d;
      front_sel_q <= front_sel_d;
      rdy_lock_q <= rdy_lock_d;
      overrun_q <= overrun_d;
      drop_q <= drop_d;
      seq_q <= seq_d;
      readdata_q <= rd_d;
      if (valid_in) begin
        cnt_q[wb] <= counter_in;
        freqs_q[wb] <= freqs_in;
        ampls_q[wb] <= ampls_in;
      end
    end
  end
endmodule

// File: doc/peak_readout_ctrl.md
Name: peak_readout_ctrl

Overview:
Ping-pong snapshot controller between the peak finder and the host register interface. Captures each peak frame (time counter, PEAKS frequencies, PEAKS amplitudes) into a back bank. Swaps banks only when the host is not mid-read, so the host never sees a torn frame. Replaces address-range gating of the readout buffer with an explicit lock/release handshake, plus ready/overrun status.

Parameters:
PEAKS, 6, peaks per frame
FREQ_WIDTH, 8, bits per frequency index (must be 8)
AMPL_WIDTH, 24, bits per amplitude (must be 24, 3 bytes)
TIME_WIDTH, 32, bits of frame time counter (must be 32, 4 bytes)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  one-cycle pulse: peak frame inputs valid this cycle
counter_in  in  TIME_WIDTH  frame time counter
freqs_in  in  PEAKS*FREQ_WIDTH  flattened frequencies, peak 0 in LSBs
ampls_in  in  PEAKS*AMPL_WIDTH  flattened amplitudes, peak 0 in LSBs
chipselect  in  1  host access select
write  in  1  host write strobe (qualified by chipselect)
address  in  8  host byte address
writedata  in  8  host write data
readdata  out  8  registered host read data
frame_ready  out  1  unread frame in front bank (usable as irq)

Behaviour:
- Byte map, front bank, big-endian:
  - 0-3: counter.
  - 4..4+PEAKS-1: freqs[i].
  - 4+PEAKS+3i .. +2: ampls[i], MSB first (default 10-27).
  - 0xF0 STATUS: bit0 frame_ready, bit1 host_lock, bit2 overrun, others 0.
  - 0xF1: drop_count (8-bit, saturating at 255).
  - 0xF2: frame_seq (8-bit, wraps, increments per swap).
  - All other addresses read 0.
- readdata <= map[address] every clk. Latency 1 cycle, independent of chipselect.
- Host write to 0xF0 (chipselect & write):
  - writedata[0]=1: lock.
  - writedata[0]=0: release.
  - writedata[2]=1: clear overrun.
  - Writes to any other address are ignored.
- State (one-hot or encoded): IDLE, READY, LOCKED. Internal flags: back_full, front_sel.
- valid_in: entire frame written to back bank in that cycle.
  - If back_full was already 1: overrun<=1, drop_count++.
  - Then back_full<=1.
- Swap occurs in any cycle where back_full=1 and state!=LOCKED (including the cycle right after capture). On swap:
  - front_sel toggles, back_full<=0, frame_seq++.
  - If state was READY: overrun<=1, drop_count++ (unread frame lost).
  - state<=READY.
- Lock:
  - From READY or IDLE: state<=LOCKED; host_lock=1.
  - Lock while LOCKED: no effect.
- Release from LOCKED:
  - state<=IDLE, frame_ready<=0.
  - A pending back_full then swaps on the next cycle, giving READY.
  - Release while not LOCKED: frame_ready<=0, state<=IDLE. If back_full=1 the swap still follows.
- frame_ready = (state==READY) | (state==LOCKED & frame-was-ready-at-lock). It clears only on release.
- Simultaneous events:
  - valid_in with lock: capture to back; no swap while LOCKED.
  - valid_in with release: capture to back; swap next cycle.
  - valid_in with an overrun clear: the set wins.
- LOCKED with continued valid_in: the back bank is overwritten and each extra frame counts as a drop. The front bank is never modified while LOCKED.
- Reset, any time, mid-lock included:
  - Both banks 0, state IDLE, back_full 0, front_sel 0.
  - Status, drop_count, frame_seq 0; readdata 0; frame_ready 0.

Test Plan:
- Reset, then read 0x00-0x1B, 0xF0-0xF2 → all 0x00; frame_ready=0.
- valid_in with counter=0x12345678, freqs[0..5]=1..6, ampl[0]=0xABCDEF → 2 cycles later frame_ready=1, STATUS=0x01, frame_seq=1. Reads: addr0=0x12, addr3=0x78, addr4=0x01, addr9=0x06, addr10/11/12=0xAB/0xCD/0xEF, each 1 cycle after the address is presented.
- Lock, then valid_in with counter=0xFFFFFFFF → addr0 still 0x12, STATUS=0x03. Release → next cycles STATUS=0x01, addr0=0xFF, frame_seq=2.
- Two valid_in frames 5 cycles apart with no lock → STATUS bit2=1, drop_count=1. Write 0x04 to 0xF0 → STATUS bit2=0.
- Lock, then 300 valid_in pulses → drop_count saturates at 0xFF, front bank unchanged.
- Assert reset while LOCKED with back_full=1 → all outputs 0, state IDLE. The next valid_in swaps normally with frame_seq=1.
